// File: rtl/fakeram7_64x21_arb.sv
// -----------------------------------------------------------------------------
// fakeram7_64x21_arb
//
// Round-robin arbiter and sequencer that lets two client blocks (A and B)
// share one fakeram7_64x21 single-port macro (64 words x 21 bits, read data
// registered inside the macro, available one cycle after the access).
//
// At most one access reaches the macro per cycle. Read data is steered back
// to the requester that issued the read. The macro control pins are driven
// to zero whenever no access is granted, so the macro never sees X.
//
// Ports
//   clk          single clock, shared with the macro
//   rst          synchronous, active-high reset
//   a_req_valid  A has an access pending
//   a_req_ready  A's access is accepted this cycle
//   a_req_we     A access type: 1 = write, 0 = read
//   a_req_addr   A word address
//   a_req_wdata  A write data
//   a_rsp_valid  a_rsp_rdata holds read data for A
//   a_rsp_rdata  read data for A
//   b_*          identical set of ports for requester B
//   ram_ce       macro ce_in
//   ram_we       macro we_in
//   ram_addr     macro addr_in
//   ram_wd       macro wd_in
//   ram_rd       macro rd_out
// -----------------------------------------------------------------------------
module fakeram7_64x21_arb #(
    parameter int BITS       = 21,
    parameter int WORD_DEPTH = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_req_we,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [BITS-1:0]       a_req_wdata,
    output logic                  a_rsp_valid,
    output logic [BITS-1:0]       a_rsp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [BITS-1:0]       b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [BITS-1:0]       b_rsp_rdata,

    output logic                  ram_ce,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [BITS-1:0]       ram_wd,
    input  logic [BITS-1:0]       ram_rd
);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    // Requester served by the most recent handshake; the other one wins the
    // next contention.
    req_e                  last_grant_q, last_grant_d;
    // A read was accepted last cycle; its data is on ram_rd this cycle.
    logic                  rd_pend_q,    rd_pend_d;
    req_e                  rd_owner_q,   rd_owner_d;

    // Arbitration result and the muxed payload of the winner.
    logic                  grant_valid;
    req_e                  grant_sel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BITS-1:0]       sel_wdata;

    // -------------------------------------------------------------------------
    // Arbitration. Nothing is granted while rst is high, which also forces
    // ready low and the macro pins to zero during reset.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_valid = 1'b0;
        grant_sel   = REQ_A;
        if (!rst) begin
            case ({a_req_valid, b_req_valid})
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_sel   = REQ_A;
                end
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_sel   = REQ_B;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    if (last_grant_q == REQ_A) begin
                        grant_sel = REQ_B;
                    end else begin
                        grant_sel = REQ_A;
                    end
                end
                default: begin
                    grant_valid = 1'b0;
                end
            endcase
        end
    end

    // Winner's payload; zero when idle so the macro pins are always defined.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (grant_valid) begin
            if (grant_sel == REQ_A) begin
                sel_we    = a_req_we;
                sel_addr  = a_req_addr;
                sel_wdata = a_req_wdata;
            end else begin
                sel_we    = b_req_we;
                sel_addr  = b_req_addr;
                sel_wdata = b_req_wdata;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic.
    // -------------------------------------------------------------------------
    always_comb begin
        last_grant_d = last_grant_q;
        rd_owner_d   = rd_owner_q;
        rd_pend_d    = 1'b0;
        if (grant_valid) begin
            last_grant_d = grant_sel;
            if (!sel_we) begin
                rd_pend_d  = 1'b1;
                rd_owner_d = grant_sel;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State register. Reset leaves last_grant at B so A wins the first
    // contention afterwards, and drops any read in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples its pre-edge inputs, independent of statement order.
        if (rst) begin
            last_grant_q <= REQ_B;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= REQ_A;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        a_req_ready = grant_valid && (grant_sel == REQ_A);
        b_req_ready = grant_valid && (grant_sel == REQ_B);

        ram_ce      = grant_valid;
        ram_we      = sel_we;
        ram_addr    = sel_addr;
        ram_wd      = sel_wdata;

        // A read accepted just before rst rises must not report a response,
        // even though the macro still updates rd_out.
        a_rsp_valid = rd_pend_q && (rd_owner_q == REQ_A) && !rst;
        b_rsp_valid = rd_pend_q && (rd_owner_q == REQ_B) && !rst;

        // The macro holds the data; both response buses just follow it.
        a_rsp_rdata = ram_rd;
        b_rsp_rdata = ram_rd;
    end

endmodule

// File: tb/tb_fakeram7_64x21_arb.sv
// -----------------------------------------------------------------------------
// Testbench for fakeram7_64x21_arb.
//
// Contains a behavioural model of the fakeram7_64x21 macro attached to the
// ram_* pins, a reference model of the arbiter (served-last bookkeeping,
// a shadow copy of memory, one pending read) checked every cycle, and
// directed scenarios with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_fakeram7_64x21_arb;

    localparam int BITS       = 21;
    localparam int WORD_DEPTH = 64;
    localparam int ADDR_WIDTH = 6;

    logic                  clk;
    logic                  rst;
    logic                  a_req_valid, a_req_ready, a_req_we;
    logic [ADDR_WIDTH-1:0] a_req_addr;
    logic [BITS-1:0]       a_req_wdata;
    logic                  a_rsp_valid;
    logic [BITS-1:0]       a_rsp_rdata;
    logic                  b_req_valid, b_req_ready, b_req_we;
    logic [ADDR_WIDTH-1:0] b_req_addr;
    logic [BITS-1:0]       b_req_wdata;
    logic                  b_rsp_valid;
    logic [BITS-1:0]       b_rsp_rdata;
    logic                  ram_ce, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [BITS-1:0]       ram_wd;
    logic [BITS-1:0]       ram_rd;

    int total = 0;
    int bad   = 0;

    fakeram7_64x21_arb #(
        .BITS       (BITS),
        .WORD_DEPTH (WORD_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_req_we    (a_req_we),
        .a_req_addr  (a_req_addr),
        .a_req_wdata (a_req_wdata),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_rdata (a_rsp_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_req_we    (b_req_we),
        .b_req_addr  (b_req_addr),
        .b_req_wdata (b_req_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_rdata (b_rsp_rdata),
        .ram_ce      (ram_ce),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wd      (ram_wd),
        .ram_rd      (ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: write on ce&we, registered read on ce&!we.
    logic [BITS-1:0] mem [WORD_DEPTH];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_wd;
            else        ram_rd        <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model, evaluated mid-cycle while inputs are stable.
    // -------------------------------------------------------------------------
    int              m_last    = 1;   // 0 = A served last, 1 = B
    bit              m_pend    = 0;
    int              m_owner   = 0;
    logic [BITS-1:0] m_data;
    logic [BITS-1:0] shadow [WORD_DEPTH];

    always @(negedge clk) begin
        bit                    g;
        int                    w;
        logic                  e_we;
        logic [ADDR_WIDTH-1:0] e_addr;
        logic [BITS-1:0]       e_wd;
        g = 0; w = 0; e_we = 0; e_addr = '0; e_wd = '0;
        if (!rst) begin
            if (a_req_valid && b_req_valid) begin g = 1; w = (m_last == 0) ? 1 : 0; end
            else if (a_req_valid)            begin g = 1; w = 0; end
            else if (b_req_valid)            begin g = 1; w = 1; end
        end
        if (g) begin
            e_we   = (w == 0) ? a_req_we    : b_req_we;
            e_addr = (w == 0) ? a_req_addr  : b_req_addr;
            e_wd   = (w == 0) ? a_req_wdata : b_req_wdata;
        end
        check("m_a_ready",  a_req_ready, 32'(g && w == 0));
        check("m_b_ready",  b_req_ready, 32'(g && w == 1));
        check("m_ram_ce",   ram_ce,      32'(g));
        check("m_ram_we",   ram_we,      32'(e_we));
        check("m_ram_addr", ram_addr,    32'(e_addr));
        check("m_ram_wd",   ram_wd,      32'(e_wd));
        check("m_a_rsp_v",  a_rsp_valid, 32'(!rst && m_pend && m_owner == 0));
        check("m_b_rsp_v",  b_rsp_valid, 32'(!rst && m_pend && m_owner == 1));
        if (!rst && m_pend) begin
            if (m_owner == 0) check("m_a_rdata", a_rsp_rdata, 32'(m_data));
            else              check("m_b_rdata", b_rsp_rdata, 32'(m_data));
        end
        // Advance to the post-edge state.
        if (rst) begin
            m_last = 1;
            m_pend = 0;
        end else begin
            m_pend = 0;
            if (g) begin
                m_last = w;
                if (e_we) shadow[e_addr] = e_wd;
                else begin
                    m_pend  = 1;
                    m_owner = w;
                    m_data  = shadow[e_addr];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Directed stimulus.
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
    endtask

    task automatic write_a(input logic [ADDR_WIDTH-1:0] addr, input logic [BITS-1:0] data);
        a_req_valid = 1; a_req_we = 1; a_req_addr = addr; a_req_wdata = data;
        tick();
    endtask

    logic [BITS-1:0] seq_data [5];

    initial begin
        seq_data[0] = 21'h00001;
        seq_data[1] = 21'h11111;
        seq_data[2] = 21'h22222;
        seq_data[3] = 21'h33333;
        seq_data[4] = 21'h44444;

        rst = 1;
        idle_inputs();
        a_req_valid = 1;   // must be ignored during reset
        @(negedge clk);
        check("rst_a_ready", a_req_ready, 0);
        check("rst_ram_ce",  ram_ce,      0);
        tick(); tick();
        rst = 0;
        idle_inputs();

        // A writes 0x0ABCD to addr 5, then reads it back.
        a_req_valid = 1; a_req_we = 1; a_req_addr = 6'd5; a_req_wdata = 21'h0ABCD;
        @(negedge clk);
        check("s1_wr_ready", a_req_ready, 1);
        check("s1_wr_we",    ram_we,      1);
        tick();
        a_req_we = 0;
        @(negedge clk);
        check("s1_rd_ready", a_req_ready, 1);
        check("s1_no_rsp",   a_rsp_valid, 0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("s1_rsp_v",    a_rsp_valid, 1);
        check("s1_rsp_d",    a_rsp_rdata, 21'h0ABCD);
        check("s1_b_rsp_v",  b_rsp_valid, 0);
        tick();
        @(negedge clk);
        check("s1_rsp_gone", a_rsp_valid, 0);

        // Preload, reset, then A and B contend with reads.
        write_a(6'd1, seq_data[1]);
        write_a(6'd2, seq_data[2]);
        write_a(6'd0, seq_data[0]);
        write_a(6'd3, seq_data[3]);
        write_a(6'd4, seq_data[4]);
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        a_req_valid = 1; a_req_addr = 6'd1;
        b_req_valid = 1; b_req_addr = 6'd2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("s2_a_ready", a_req_ready, 32'(k % 2 == 0));
            check("s2_b_ready", b_req_ready, 32'(k % 2 == 1));
            check("s2_ce",      ram_ce,      1);
            if (k % 2 == 1) begin
                check("s2_a_rsp_v", a_rsp_valid, 1);
                check("s2_a_rsp_d", a_rsp_rdata, 21'h11111);
            end else if (k > 0) begin
                check("s2_b_rsp_v", b_rsp_valid, 1);
                check("s2_b_rsp_d", b_rsp_rdata, 21'h22222);
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("s2_b_rsp_last_v", b_rsp_valid, 1);
        check("s2_b_rsp_last_d", b_rsp_rdata, 21'h22222);
        tick();

        // Idle: pins at zero, no responses.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("s3_ce",   ram_ce, 0);
            check("s3_pins", {ram_we, ram_addr, ram_wd}, 0);
            check("s3_rsp",  a_rsp_valid | b_rsp_valid, 0);
            tick();
        end

        // A writes addr 63, B reads 63 then 0.
        a_req_valid = 1; a_req_we = 1; a_req_addr = 6'd63; a_req_wdata = 21'h1F00F;
        @(negedge clk);
        check("s4_wr_addr", ram_addr, 63);
        tick();
        idle_inputs();
        b_req_valid = 1; b_req_addr = 6'd63;
        @(negedge clk);
        check("s4_b_ready", b_req_ready, 1);
        tick();
        b_req_addr = 6'd0;
        @(negedge clk);
        check("s4_rsp63_v", b_rsp_valid, 1);
        check("s4_rsp63_d", b_rsp_rdata, 21'h1F00F);
        tick();
        idle_inputs();
        @(negedge clk);
        check("s4_rsp0_d", b_rsp_rdata, 21'h00001);
        tick();

        // B read handshake, then reset for 2 cycles.
        b_req_valid = 1; b_req_addr = 6'd2;
        @(negedge clk);
        check("s5_b_ready", b_req_ready, 1);
        tick();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        check("s5_rst_rsp0", b_rsp_valid, 0);
        tick();
        @(negedge clk);
        check("s5_rst_rsp1", b_rsp_valid, 0);
        tick();
        rst = 0;
        a_req_valid = 1; a_req_addr = 6'd1;
        b_req_valid = 1; b_req_addr = 6'd2;
        @(negedge clk);
        check("s5_a_wins",  a_req_ready, 1);
        check("s5_b_waits", b_req_ready, 0);
        check("s5_no_rsp",  b_rsp_valid, 0);
        tick();
        idle_inputs();
        tick();

        // Only B: reads of addrs 0..4 back to back.
        for (int k = 0; k < 5; k++) begin
            b_req_valid = 1; b_req_addr = 6'(k);
            @(negedge clk);
            check("s6_b_ready", b_req_ready, 1);
            if (k > 0) begin
                check("s6_rsp_v", b_rsp_valid, 1);
                check("s6_rsp_d", b_rsp_rdata, 32'(seq_data[k-1]));
            end
            tick();
        end
        idle_inputs();
        @(negedge clk);
        check("s6_rsp_last_v", b_rsp_valid, 1);
        check("s6_rsp_last_d", b_rsp_rdata, 21'h44444);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fakeram7_64x21_arb.md
Name: fakeram7_64x21_arb

Overview:
- Two-requester round-robin arbiter and sequencer for one fakeram7_64x21 single-port macro (64 words x 21 bits, 1-cycle registered read).
- Sits between two client blocks and the macro pins.
- Issues at most one access per cycle and returns read data to the requester that issued the read.
- Keeps macro control pins at known values at all times, so the macro never sees X on ce/we/addr.

Parameters:
- BITS, 21, data width; must match the macro.
- WORD_DEPTH, 64, number of macro words.
- ADDR_WIDTH, 6, address width; log2(WORD_DEPTH).

Ports:
- clk  input  1  single clock, shared with the macro.
- rst  input  1  synchronous, active-high reset.
- a_req_valid  input  1  requester A has an access pending.
- a_req_ready  output  1  requester A's access is accepted this cycle.
- a_req_we  input  1  1 = write, 0 = read.
- a_req_addr  input  ADDR_WIDTH  word address.
- a_req_wdata  input  BITS  write data.
- a_rsp_valid  output  1  a_rsp_rdata holds read data for A.
- a_rsp_rdata  output  BITS  read data for A.
- b_req_valid, b_req_ready, b_req_we, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as the A ports, for requester B.
- ram_ce  output  1  to macro ce_in.
- ram_we  output  1  to macro we_in.
- ram_addr  output  ADDR_WIDTH  to macro addr_in.
- ram_wd  output  BITS  to macro wd_in.
- ram_rd  input  BITS  from macro rd_out.

Behaviour:
- Reset (synchronous, rst high at posedge clk):
  - last_grant <= B, so A wins the first contention.
  - rd_pend <= 0; rd_owner <= A.
  - a_rsp_valid = b_rsp_valid = 0.
  - While rst is high: ready outputs 0, ram_ce 0, ram_we 0, ram_addr 0, ram_wd 0.
- Arbitration (combinational, each cycle):
  - Only A valid: grant A. Only B valid: grant B.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
  - Granted requester's ready = 1; the other's ready = 0.
  - Handshake = valid & ready. Requesters hold valid and payload stable until ready.
- Macro drive (same cycle as the handshake, combinational from the grant mux):
  - ram_ce = 1, ram_we = req_we, ram_addr = req_addr, ram_wd = req_wdata.
  - Without a grant: ram_ce = 0, ram_we = 0, ram_addr = 0, ram_wd = 0. Idle pins are never X or floating.
- State update on every handshake: last_grant <= granted requester.
- Read tracking:
  - Read handshake (we = 0): rd_pend <= 1, rd_owner <= granted requester.
  - Otherwise: rd_pend <= 0.
- Response (one cycle after the read handshake):
  - Owner's rsp_valid = rd_pend, and its rsp_rdata = ram_rd.
  - Non-owner's rsp_valid = 0; its rsp_rdata is don't-care, driven with ram_rd.
  - Read latency is exactly 1 cycle after the handshake. Responses cannot be stalled.
- Writes produce no response. Write data is presented to the macro unmodified; bit-combining semantics belong to the macro model.
- Back-to-back accesses are allowed at full rate (one per cycle). A read response and a new grant may occur in the same cycle.
- Same-address read after write: the read in the next cycle returns post-write content. No forwarding in the arbiter.
- Reset mid-operation: a read handshaken in the cycle before rst rises produces no response. rd_pend is cleared and rsp_valid stays 0, even though the macro updates rd_out.
- Fairness: under continuous contention the grant alternates A, B, A, B. Maximum wait is 1 cycle.
- No internal buffering, no X checks. Requesters must not present X on a valid access.

Test Plan:
- Reset, then A writes 0x0ABCD to addr 5, then A reads addr 5 -> a_rsp_valid = 1 exactly one cycle after the read handshake, a_rsp_rdata = 0x0ABCD, b_rsp_valid = 0 throughout.
- A and B both valid reads (A addr 1, B addr 2) held for 4 cycles after reset -> grants A, B, A, B; responses alternate owner with the matching data; ram_ce = 1 every cycle.
- Idle for 10 cycles -> ram_ce = 0, ram_we = 0, ram_addr = 0, ram_wd = 0 every cycle; no rsp_valid.
- A write to addr 63 followed immediately by a B read of addr 63 -> B gets the written value one cycle after its grant; the addr 63 -> 0 boundary causes no wrap error.
- Read handshake on B, then rst asserted the next cycle for 2 cycles -> b_rsp_valid stays 0. After release, the first contention goes to A.
- Only B valid for 5 back-to-back reads of addrs 0..4 -> b_req_ready = 1 every cycle; 5 consecutive b_rsp_valid pulses in address order.
